// File: rtl/shark_sprite_engine.sv
// Shark sprite: swims between horizontal bounds with a vertical bob and flashes after a hit.
// Draws a registered body/eye pixel pair against the VGA raster.
module shark_sprite_engine #(
    parameter logic signed [11:0] SPAWN_X    = 12'sd600,
    parameter logic signed [11:0] SPAWN_Y    = 12'sd240,
    parameter logic signed [11:0] X_MIN      = 12'sd60,
    parameter logic signed [11:0] X_MAX      = 12'sd620,
    parameter int unsigned        SPEED      = 3,
    parameter int unsigned        BOB_AMP    = 4,
    parameter int unsigned        BOB_DIV    = 4,
    parameter int unsigned        HIT_FRAMES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_tick,
    input  logic               hit,
    input  logic               blank,
    input  logic signed [11:0] hcount,
    input  logic signed [11:0] vcount,
    output logic               shark,
    output logic               sharkEyes,
    output logic signed [11:0] sharkX,
    output logic signed [11:0] sharkY,
    output logic               alive
);

    localparam int unsigned CNT_W = ($clog2(HIT_FRAMES) > 3) ? $clog2(HIT_FRAMES) : 3;
    localparam int unsigned DIV_W = (BOB_DIV > 1) ? $clog2(BOB_DIV) : 1;

    localparam logic signed [12:0] SPEED_S = 13'(SPEED);
    localparam logic signed [12:0] XMIN_S  = 13'(X_MIN);
    localparam logic signed [12:0] XMAX_S  = 13'(X_MAX);
    localparam logic signed [4:0]  AMP_S   = 5'(BOB_AMP);

    typedef enum logic [1:0] {IDLE, SWIM_L, SWIM_R, HIT} state_t;

    state_t             state_q, state_d;
    logic signed [11:0] x_q, x_d;
    logic signed [11:0] y_q, y_d;
    logic signed [4:0]  off_q, off_d;
    logic               bdir_q, bdir_d;   // 1: bobbing up (offset decreasing)
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               face_q, face_d;   // facing left when the hit landed
    logic               alive_q, alive_d;
    logic               shark_q, shark_d;
    logic               eyes_q, eyes_d;

    logic signed [12:0] x_ext, x_nx;
    logic signed [4:0]  off_nx;

    // Motion, bob and hit-flash control
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        off_d   = off_q;
        bdir_d  = bdir_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        face_d  = face_q;
        x_ext   = x_q;
        x_nx    = x_ext;
        off_nx  = off_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = SWIM_L;
                SWIM_L, SWIM_R: begin
                    if (hit) begin
                        state_d = HIT;
                        cnt_d   = CNT_W'(HIT_FRAMES - 1);
                        face_d  = (state_q == SWIM_L);
                    end else if (frame_tick) begin
                        if (state_q == SWIM_L) begin
                            x_nx = x_ext - SPEED_S;
                            if (x_nx <= XMIN_S) begin
                                x_d     = X_MIN;
                                state_d = SWIM_R;
                            end else begin
                                x_d = 12'(x_nx);
                            end
                        end else begin
                            x_nx = x_ext + SPEED_S;
                            if (x_nx >= XMAX_S) begin
                                x_d     = X_MAX;
                                state_d = SWIM_L;
                            end else begin
                                x_d = 12'(x_nx);
                            end
                        end
                        if (div_q == DIV_W'(BOB_DIV - 1)) begin
                            div_d = '0;
                            if (BOB_AMP != 0) begin
                                off_nx = bdir_q ? (off_q - 5'sd1) : (off_q + 5'sd1);
                                off_d  = off_nx;
                                if (off_nx == AMP_S) begin
                                    bdir_d = 1'b1;
                                end else if (off_nx == -AMP_S) begin
                                    bdir_d = 1'b0;
                                end
                            end
                        end else begin
                            div_d = DIV_W'(div_q + 1'b1);
                        end
                    end
                end
                HIT: begin
                    if (frame_tick) begin
                        if (cnt_q == '0) begin
                            state_d = SWIM_L;
                            x_d     = SPAWN_X;
                            off_d   = '0;
                            bdir_d  = 1'b0;
                            div_d   = '0;
                        end else begin
                            cnt_d = CNT_W'(cnt_q - 1'b1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        y_d     = SPAWN_Y + 12'(off_d);
        alive_d = (state_d == SWIM_L) || (state_d == SWIM_R);
    end

    logic               face_left;
    logic signed [15:0] dx, dv;
    logic               r1, r2, r3, r4, eye_hit, pix_en;

    // Sprite geometry relative to the anchor, mirrored when facing right
    always_comb begin
        face_left = (state_q == SWIM_L) || ((state_q == HIT) && face_q);
        dv = 16'(vcount) - 16'(y_q);
        dx = face_left ? (16'(hcount) - 16'(x_q)) : (16'(x_q) - 16'(hcount));

        r1 = (dx >= -16'sd55) && (dx <= -16'sd20)
          && ((16'sd3 * (dv - 16'sd10)) <= (dx + 16'sd40))
          && ((dv - 16'sd10) <= -(dx + 16'sd25))
          && (dv > -16'sd5) && (dv < 16'sd10);
        r2 = (dx > -16'sd35) && (dx <= -16'sd25)
          && ((dv + 16'sd5) >= -(dx + 16'sd35))
          && (dv > -16'sd15) && (dv <= -16'sd5);
        r3 = ((dv - 16'sd5) <= -(dx + 16'sd10))
          && (dx >= -16'sd20) && (dx <= -16'sd5)
          && (dv > -16'sd5) && (dv < 16'sd5);
        r4 = (dx >= -16'sd5) && (dx <= 16'sd2) && (dv >= -16'sd10) && (dv <= 16'sd7);
        eye_hit = (dx >= -16'sd50) && (dx <= -16'sd46) && (dv >= -16'sd3) && (dv <= 16'sd0);

        // cnt_q[2] set marks a blink-off frame while flashing
        pix_en  = enable && !blank && (state_q != IDLE) && !((state_q == HIT) && cnt_q[2]);
        shark_d = pix_en && (r1 || r2 || r3 || r4);
        eyes_d  = pix_en && eye_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= SPAWN_X;
            y_q     <= SPAWN_Y;
            off_q   <= '0;
            bdir_q  <= 1'b0;
            div_q   <= '0;
            cnt_q   <= '0;
            face_q  <= 1'b1;
            alive_q <= 1'b0;
            shark_q <= 1'b0;
            eyes_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            off_q   <= off_d;
            bdir_q  <= bdir_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            face_q  <= face_d;
            alive_q <= alive_d;
            shark_q <= shark_d;
            eyes_q  <= eyes_d;
        end
    end

    assign shark     = shark_q;
    assign sharkEyes = eyes_q;
    assign sharkX    = x_q;
    assign sharkY    = y_q;
    assign alive     = alive_q;

endmodule
